// File: rtl/mem_ctrl_defs.sv
// Shared definitions for the data-memory access controller and the data memory.
// Holds the FSM state encodings, the default bus widths shared with the data
// memory, and the width of the load wait-state counter.
package mem_ctrl_defs;

  localparam int unsigned DEF_DATA_WIDTH = 4;
  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned WAIT_CNT_WIDTH = 4;

  typedef logic [1:0]                state_t;
  typedef logic [WAIT_CNT_WIDTH-1:0] wait_cnt_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_ACCESS = 2'd1;
  localparam state_t S_RESP   = 2'd2;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake bundle between the CPU memory stage and the
// access controller.
//   master : CPU side  - drives req_valid/req_write/req_addr/req_wdata, rsp_ready
//   slave  : controller - drives req_ready, rsp_valid/rsp_write/rsp_rdata
interface mem_access_ctrl_if
  import mem_ctrl_defs::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_write;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_write, rsp_rdata
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Loadable down-counter used to stretch load accesses by a number of wait
// states. done is high whenever the count is zero; decrementing stops at zero.
//   clock, reset_n : clock and asynchronous active-low reset
//   load, load_value : load the counter (load has priority over dec)
//   dec            : decrement by one while nonzero
//   done           : count == 0
module mem_wait_timer
  import mem_ctrl_defs::*;
(
  input  logic      clock,
  input  logic      reset_n,
  input  logic      load,
  input  wait_cnt_t load_value,
  input  logic      dec,
  output logic      done
);

  wait_cnt_t count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator between the CPU memory stage and the data memory.
// One request at a time is accepted over bus (req_*), driven onto the memory
// lines, and answered with a held response over bus (rsp_*).
//   clock, reset_n  : clock, asynchronous active-low reset
//   bus             : request/response handshake (slave side)
//   mem_address     : data memory word address (registered at accept)
//   mem_write_data  : data memory write data (registered at accept)
//   mem_write       : write enable, high for the single store ACCESS cycle
//   mem_read        : read enable, high for every load ACCESS cycle
//   mem_read_data   : data memory read data
//   busy            : controller is not IDLE
module mem_access_ctrl
  import mem_ctrl_defs::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  mem_access_ctrl_if.slave      bus,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  busy
);

  localparam wait_cnt_t LOAD_WAIT = wait_cnt_t'(WAIT_STATES);

  state_t                state;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rsp_write_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  req_ready_int;
  logic                  accept;
  logic                  in_access;
  logic                  timer_done;

  // reset_n is folded in so req_ready is low while reset is held.
  assign req_ready_int = (state == S_IDLE) & reset_n;
  assign accept        = bus.req_valid & req_ready_int;
  assign in_access     = (state == S_ACCESS);

  mem_wait_timer u_wait_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (accept),
    .load_value (bus.req_write ? wait_cnt_t'(0) : LOAD_WAIT),
    .dec        (in_access & ~wr_q),
    .done       (timer_done)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state   <= S_ACCESS;
            wr_q    <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
          end
        end
        S_ACCESS: begin
          if (wr_q) begin
            state       <= S_RESP;
            rsp_write_q <= 1'b1;
            rsp_rdata_q <= '0;
          end else if (timer_done) begin
            // Exit edge of a load doubles as the read-data sample edge.
            state       <= S_RESP;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= mem_read_data;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_int;
  assign bus.rsp_valid  = (state == S_RESP);
  assign bus.rsp_write  = rsp_write_q;
  assign bus.rsp_rdata  = rsp_rdata_q;

  // Enables decode from the registered state, so an async reset drops them
  // immediately and a store aborted before its edge never writes.
  assign mem_write      = in_access & wr_q;
  assign mem_read       = in_access & ~wr_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign busy           = (state != S_IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // dut1: WAIT_STATES=1, dut0: WAIT_STATES=0
  logic       rst1_n, rst0_n;
  logic [4:0] ma1, ma0;
  logic [3:0] mwd1, mwd0, mrd1, mrd0;
  logic       mw1, mw0, mr1, mr0, busy1, busy0;

  mem_access_ctrl_if #(.DATA_WIDTH(4), .ADDR_WIDTH(5)) bus1 ();
  mem_access_ctrl_if #(.DATA_WIDTH(4), .ADDR_WIDTH(5)) bus0 ();

  mem_access_ctrl #(.DATA_WIDTH(4), .ADDR_WIDTH(5), .WAIT_STATES(1)) dut1 (
    .clock(clk), .reset_n(rst1_n), .bus(bus1),
    .mem_address(ma1), .mem_write_data(mwd1), .mem_write(mw1), .mem_read(mr1),
    .mem_read_data(mrd1), .busy(busy1)
  );

  mem_access_ctrl #(.DATA_WIDTH(4), .ADDR_WIDTH(5), .WAIT_STATES(0)) dut0 (
    .clock(clk), .reset_n(rst0_n), .bus(bus0),
    .mem_address(ma0), .mem_write_data(mwd0), .mem_write(mw0), .mem_read(mr0),
    .mem_read_data(mrd0), .busy(busy0)
  );

  // Data memory models: synchronous write, combinational read.
  logic [3:0] mem1 [32];
  logic [3:0] mem0 [32];
  always @(posedge clk) if (mw1) mem1[ma1] <= mwd1;
  always @(posedge clk) if (mw0) mem0[ma0] <= mwd0;
  assign mrd1 = mr1 ? mem1[ma1] : 4'h0;
  assign mrd0 = mr0 ? mem0[ma0] : 4'h0;

  typedef struct { bit w; int rd; int lat; } exp_t;
  exp_t q1[$];
  exp_t q0[$];
  int acc1 = 0, acc0 = 0;
  bit pv1 = 1'b0, pv0 = 1'b0;

  // Monitors: record accept cycles, check each response as rsp_valid rises.
  always @(negedge clk) begin
    exp_t e;
    if (bus1.req_valid && bus1.req_ready) acc1 = cyc;
    if (bus1.rsp_valid && !pv1) begin
      if (q1.size() == 0) chk("rsp1_unexpected", 1, 0);
      else begin
        e = q1.pop_front();
        chk("rsp1_write", int'(bus1.rsp_write), int'(e.w));
        chk("rsp1_rdata", int'(bus1.rsp_rdata), e.rd);
        chk("rsp1_latency", cyc - acc1, e.lat);
      end
    end
    pv1 = bus1.rsp_valid;
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus0.req_valid && bus0.req_ready) acc0 = cyc;
    if (bus0.rsp_valid && !pv0) begin
      if (q0.size() == 0) chk("rsp0_unexpected", 1, 0);
      else begin
        e = q0.pop_front();
        chk("rsp0_write", int'(bus0.rsp_write), int'(e.w));
        chk("rsp0_rdata", int'(bus0.rsp_rdata), e.rd);
        chk("rsp0_latency", cyc - acc0, e.lat);
      end
    end
    pv0 = bus0.rsp_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 of cycle 1 with req_valid low.
  task automatic send(input int d, input bit w, input int a, input int wd,
                      input bit push, input int erd, input int lat, output int acc);
    exp_t e;
    bit got;
    e.w = w; e.rd = erd; e.lat = lat;
    if (push) begin
      if (d == 1) q1.push_back(e); else q0.push_back(e);
    end
    if (d == 1) begin
      bus1.req_valid = 1'b1; bus1.req_write = w;
      bus1.req_addr = 5'(a); bus1.req_wdata = 4'(wd);
    end else begin
      bus0.req_valid = 1'b1; bus0.req_write = w;
      bus0.req_addr = 5'(a); bus0.req_wdata = 4'(wd);
    end
    got = 1'b0;
    acc = cyc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((d == 1) ? bus1.req_ready : bus0.req_ready) begin
        got = 1'b1;
        acc = cyc;
        break;
      end
    end
    if (!got) chk("accept_timeout", 0, 1);
    step();
    if (d == 1) bus1.req_valid = 1'b0; else bus0.req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, a3, ax;
    for (int i = 0; i < 32; i++) begin
      mem1[i] = 4'h0;
      mem0[i] = 4'h0;
    end
    mem1[3] = 4'h5;
    rst1_n = 1'b0; rst0_n = 1'b0;
    bus1.req_valid = 1'b1; bus1.req_write = 1'b1; bus1.req_addr = 5'd9;  bus1.req_wdata = 4'h6;
    bus0.req_valid = 1'b1; bus0.req_write = 1'b0; bus0.req_addr = 5'd9;  bus0.req_wdata = 4'h6;
    bus1.rsp_ready = 1'b1; bus0.rsp_ready = 1'b1;

    // Reset held with a request pending
    repeat (2) @(negedge clk);
    chk("rst_req_ready",  int'(bus1.req_ready), 0);
    chk("rst_rsp_valid",  int'(bus1.rsp_valid), 0);
    chk("rst_rsp_write",  int'(bus1.rsp_write), 0);
    chk("rst_rsp_rdata",  int'(bus1.rsp_rdata), 0);
    chk("rst_mem_addr",   int'(ma1), 0);
    chk("rst_mem_wdata",  int'(mwd1), 0);
    chk("rst_mem_enables", int'({mw1, mr1, mw0, mr0}), 0);
    chk("rst_busy",       int'({busy1, busy0}), 0);
    step();
    bus1.req_valid = 1'b0; bus0.req_valid = 1'b0;
    rst1_n = 1'b1; rst0_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready1", int'(bus1.req_ready), 1);
    chk("post_rst_req_ready0", int'(bus0.req_ready), 1);
    step();

    // Store addr 5 = 0xA
    send(1, 1'b1, 5, 10, 1'b1, 0, 2, ax);
    @(negedge clk);
    chk("st_mem_write_c1", int'(mw1), 1);
    chk("st_mem_read_c1",  int'(mr1), 0);
    chk("st_mem_addr_c1",  int'(ma1), 5);
    chk("st_mem_wdata_c1", int'(mwd1), 10);
    chk("st_busy_c1",      int'(busy1), 1);
    @(negedge clk);
    chk("st_mem_write_c2", int'(mw1), 0);
    @(negedge clk);
    chk("st_req_ready_c3", int'(bus1.req_ready), 1);
    step();

    // Load addr 5 (two read cycles)
    send(1, 1'b0, 5, 0, 1'b1, 10, 3, ax);
    @(negedge clk);
    chk("ld_mem_read_c1", int'(mr1), 1);
    chk("ld_mem_addr_c1", int'(ma1), 5);
    @(negedge clk);
    chk("ld_mem_read_c2",  int'(mr1), 1);
    chk("ld_mem_write_c2", int'(mw1), 0);
    @(negedge clk);
    chk("ld_mem_read_c3", int'(mr1), 0);
    @(negedge clk);
    chk("ld_req_ready_c4", int'(bus1.req_ready), 1);
    step();

    // Backpressure with a second request waiting
    bus1.rsp_ready = 1'b0;
    send(1, 1'b0, 5, 0, 1'b1, 10, 3, ax);
    begin
      exp_t e2;
      e2.w = 1'b1; e2.rd = 0; e2.lat = 2;
      q1.push_back(e2);
    end
    bus1.req_valid = 1'b1; bus1.req_write = 1'b1; bus1.req_addr = 5'd7; bus1.req_wdata = 4'h3;
    repeat (2) begin
      @(negedge clk);
      chk("bp_req_ready_access", int'(bus1.req_ready), 0);
    end
    repeat (5) begin
      @(negedge clk);
      chk("bp_rsp_valid", int'(bus1.rsp_valid), 1);
      chk("bp_rsp_rdata", int'(bus1.rsp_rdata), 10);
      chk("bp_rsp_write", int'(bus1.rsp_write), 0);
      chk("bp_req_ready", int'(bus1.req_ready), 0);
    end
    step();
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_rsp_valid", int'(bus1.rsp_valid), 1);
    chk("bp_hs_req_ready", int'(bus1.req_ready), 0);
    step();
    @(negedge clk);
    chk("bp_next_req_ready", int'(bus1.req_ready), 1);
    step();
    bus1.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    step();

    // Reset during a store access, before its write edge
    send(1, 1'b1, 3, 7, 1'b0, 0, 0, ax);
    #1;
    chk("abort_mw_before", int'(mw1), 1);
    rst1_n = 1'b0;
    #1;
    chk("abort_mw_after",   int'(mw1), 0);
    chk("abort_busy",       int'(busy1), 0);
    chk("abort_mem_addr",   int'(ma1), 0);
    chk("abort_req_ready",  int'(bus1.req_ready), 0);
    step();
    rst1_n = 1'b1;
    send(1, 1'b0, 3, 0, 1'b1, 5, 3, ax);
    repeat (4) @(negedge clk);
    step();

    // Boundary addresses on the zero-wait-state instance
    send(0, 1'b1, 31, 15, 1'b1, 0, 2, a0);
    send(0, 1'b1, 0, 1, 1'b1, 0, 2, a1);
    chk("bnd_store_spacing", a1 - a0, 3);
    send(0, 1'b0, 31, 0, 1'b1, 15, 2, a2);
    chk("bnd_store_load_spacing", a2 - a1, 3);
    send(0, 1'b0, 0, 0, 1'b1, 1, 2, a3);
    chk("bnd_load_spacing", a3 - a2, 3);
    repeat (5) @(negedge clk);

    chk("q1_drained", q1.size(), 0);
    chk("q0_drained", q0.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
